// File: rtl/alu_multicycle_if.sv
// Request/result bundle for alu_multicycle.
// master: the issuing pipeline stage; slave: the ALU.
interface alu_multicycle_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_operandA;
  logic [WIDTH-1:0]   data_operandB;
  logic [4:0]         ctrl_ALUopcode;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_result;
  logic               isNotEqual;
  logic               isLessThan;
  logic               overflow;
  logic               exception;

  modport master (
    output in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
    input  in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow, exception
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
    output in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow, exception
  );
endinterface

// File: rtl/alu_multicycle.sv
// Handshaked integer ALU with registered results and iterative signed MUL/DIV.
// Single-cycle ops complete on the accept edge; MUL/DIV run WIDTH shift
// iterations on operand magnitudes followed by one sign-fixup cycle.
// Build option: define ALU_MULTICYCLE_DIV_EN to include the divider; without it
// opcode 7 is treated as illegal and no divider logic exists.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no result pending, ready for a request
// S_BUSY | MUL/DIV iterating; handshakes ignored
// S_DONE | result registers valid; may accept a new request on out_ready
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic             clock,
  input logic             reset,
  alu_multicycle_if.slave bus
);
  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;
  localparam logic [4:0] OP_MUL = 5'd6;
`ifdef ALU_MULTICYCLE_DIV_EN
  localparam logic [4:0] OP_DIV = 5'd7;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] acc_q;     // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   bmag_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic [WIDTH-1:0]   result_q;
  logic               out_valid_q, ne_q, lt_q, ovf_q, exc_q;
`ifdef ALU_MULTICYCLE_DIV_EN
  logic               div_q;
`endif

  logic [WIDTH-1:0]   op_a, op_b;
  logic [WIDTH-1:0]   sum, diff, amag, bmag, res_d;
  logic               add_ovf, sub_ovf, ovf_d, exc_d, iter_d;
  logic               in_ready_w, accept;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod_s;
  logic               mul_ovf;
`ifdef ALU_MULTICYCLE_DIV_EN
  logic               div_sel_d, rem_ge;
  logic [WIDTH:0]     rem_sh;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_s;
`endif

  assign op_a       = bus.data_operandA;
  assign op_b       = bus.data_operandB;
  assign in_ready_w = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign accept     = bus.in_valid && in_ready_w;

  // Single-cycle results, flags and dispatch decision for the offered request
  always_comb begin
    sum     = op_a + op_b;
    diff    = op_a - op_b;
    add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
    amag    = op_a[WIDTH-1] ? -op_a : op_a;
    bmag    = op_b[WIDTH-1] ? -op_b : op_b;
    res_d   = '0;
    ovf_d   = 1'b0;
    exc_d   = 1'b0;
    iter_d  = 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
    div_sel_d = 1'b0;
`endif
    case (bus.ctrl_ALUopcode)
      OP_ADD: begin res_d = sum;  ovf_d = add_ovf; end
      OP_SUB: begin res_d = diff; ovf_d = sub_ovf; end
      OP_AND: res_d = op_a & op_b;
      OP_OR:  res_d = op_a | op_b;
      OP_SLL: res_d = op_a << bus.ctrl_shiftamt;
      OP_SRA: res_d = $unsigned($signed(op_a) >>> bus.ctrl_shiftamt);
      OP_MUL: iter_d = 1'b1;
`ifdef ALU_MULTICYCLE_DIV_EN
      OP_DIV: begin
        // Zero divisor and MIN / -1 are resolved immediately; they never iterate.
        if (op_b == '0) begin
          exc_d = 1'b1;
        end else if ((op_a == MIN_VAL) && (op_b == '1)) begin
          res_d = MIN_VAL;
          ovf_d = 1'b1;
        end else begin
          iter_d    = 1'b1;
          div_sel_d = 1'b1;
        end
      end
`endif
      default: exc_d = 1'b1;
    endcase
  end

  // One iteration step and the final sign fixup for the iterative ops
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc_q[0]}} & {1'b0, bmag_q});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    prod_s   = neg_q ? -acc_q : acc_q;
    // Product fits WIDTH bits only when the upper half is the sign extension.
    mul_ovf  = !((&prod_s[2*WIDTH-1:WIDTH-1]) || (~|prod_s[2*WIDTH-1:WIDTH-1]));
`ifdef ALU_MULTICYCLE_DIV_EN
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, bmag_q});
    div_next = {(rem_ge ? (rem_sh[WIDTH-1:0] - bmag_q) : rem_sh[WIDTH-1:0]),
                acc_q[WIDTH-2:0], rem_ge};
    quo_s    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
`endif
  end

  // Control FSM with registered datapath and outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      bmag_q      <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      ne_q        <= 1'b0;
      lt_q        <= 1'b0;
      ovf_q       <= 1'b0;
      exc_q       <= 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
      div_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            ne_q <= (op_a != op_b);
            lt_q <= diff[WIDTH-1] ^ sub_ovf;
            if (iter_d) begin
              state_q     <= S_BUSY;
              out_valid_q <= 1'b0;
              acc_q       <= {{WIDTH{1'b0}}, amag};
              bmag_q      <= bmag;
              neg_q       <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
              cnt_q       <= CNT_W'(WIDTH - 1);
`ifdef ALU_MULTICYCLE_DIV_EN
              div_q       <= div_sel_d;
`endif
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= res_d;
              ovf_q       <= ovf_d;
              exc_q       <= exc_d;
            end
          end else if ((state_q == S_DONE) && bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        S_BUSY: begin
          // Counter runs WIDTH-1..0 for the shift steps; its wrap to a set MSB
          // marks the fixup cycle.
          if (!cnt_q[CNT_W-1]) begin
            cnt_q <= cnt_q - 1'b1;
`ifdef ALU_MULTICYCLE_DIV_EN
            acc_q <= div_q ? div_next : mul_next;
`else
            acc_q <= mul_next;
`endif
          end else begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            exc_q       <= 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
            result_q    <= div_q ? quo_s : prod_s[WIDTH-1:0];
            ovf_q       <= div_q ? 1'b0 : mul_ovf;
`else
            result_q    <= prod_s[WIDTH-1:0];
            ovf_q       <= mul_ovf;
`endif
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = out_valid_q;
  assign bus.data_result = result_q;
  assign bus.isNotEqual  = ne_q;
  assign bus.isLessThan  = lt_q;
  assign bus.overflow    = ovf_q;
  assign bus.exception   = exc_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: a 32-bit and an 8-bit instance share clock/reset.
// Expected DIV behaviour follows ALU_MULTICYCLE_DIV_EN as compiled.
module tb_alu_multicycle;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  alu_multicycle_if #(.WIDTH(32), .SHAMT_W(5)) bus32 ();
  alu_multicycle_if #(.WIDTH(8),  .SHAMT_W(3)) bus8 ();

  alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) u_dut32 (.clock(clock), .reset(reset), .bus(bus32));
  alu_multicycle #(.WIDTH(8),  .SHAMT_W(3)) u_dut8  (.clock(clock), .reset(reset), .bus(bus8));

  typedef struct {
    logic [31:0] res;
    logic        ovf, exc, lt, ne;
    int          lat;   // edges after the accept edge until out_valid
  } exp_t;

  typedef struct {
    bit          n;
    string       name;
    logic [31:0] a, b;
    logic [4:0]  op, sh;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed integer arithmetic on longint, then range/mask
  function automatic exp_t model(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                                 input logic [4:0] op, input logic [4:0] sh);
    longint lim  = longint'(1) << (w - 1);
    longint mask = (longint'(1) << w) - 1;
    longint ua   = longint'(a_in) & mask;
    longint ub   = longint'(b_in) & mask;
    longint sa   = (ua >= lim) ? ua - 2 * lim : ua;
    longint sb   = (ub >= lim) ? ub - 2 * lim : ub;
    int     s    = int'(sh) & (w - 1);
    longint full = 0;
    exp_t   e;
    e.res = '0; e.ovf = 0; e.exc = 0; e.lat = 0;
    e.ne  = (ua != ub);
    e.lt  = (sa < sb);
    case (op)
      5'd0: begin full = sa + sb; e.res = 32'(full & mask); e.ovf = (full >= lim) || (full < -lim); end
      5'd1: begin full = sa - sb; e.res = 32'(full & mask); e.ovf = (full >= lim) || (full < -lim); end
      5'd2: e.res = 32'(ua & ub);
      5'd3: e.res = 32'(ua | ub);
      5'd4: e.res = 32'((ua << s) & mask);
      5'd5: e.res = 32'((sa >>> s) & mask);
      5'd6: begin
        full  = sa * sb;
        e.res = 32'(full & mask);
        e.ovf = (full >= lim) || (full < -lim);
        e.lat = w + 1;
      end
`ifdef ALU_MULTICYCLE_DIV_EN
      5'd7: begin
        if (sb == 0) e.exc = 1;
        else begin
          full  = sa / sb;
          e.res = 32'(full & mask);
          e.ovf = (full >= lim) || (full < -lim);
          e.lat = e.ovf ? 0 : w + 1;
        end
      end
`endif
      default: e.exc = 1;
    endcase
    return e;
  endfunction

  task automatic set_in(input bit n, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input logic [4:0] sh);
    if (n) begin
      bus8.in_valid = v; bus8.data_operandA = a[7:0]; bus8.data_operandB = b[7:0];
      bus8.ctrl_ALUopcode = op; bus8.ctrl_shiftamt = sh[2:0];
    end else begin
      bus32.in_valid = v; bus32.data_operandA = a; bus32.data_operandB = b;
      bus32.ctrl_ALUopcode = op; bus32.ctrl_shiftamt = sh;
    end
  endtask

  task automatic get_out(input bit n, output logic ov, output logic ir, output logic [31:0] res,
                         output logic ne, output logic lt, output logic ovf, output logic exc);
    if (n) begin
      ov = bus8.out_valid; ir = bus8.in_ready; res = {24'd0, bus8.data_result};
      ne = bus8.isNotEqual; lt = bus8.isLessThan; ovf = bus8.overflow; exc = bus8.exception;
    end else begin
      ov = bus32.out_valid; ir = bus32.in_ready; res = bus32.data_result;
      ne = bus32.isNotEqual; lt = bus32.isLessThan; ovf = bus32.overflow; exc = bus32.exception;
    end
  endtask

  // Issue one op from idle, check latency and outputs, then drain it
  task automatic run_op(input bit n, input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input logic [4:0] sh, input exp_t e);
    logic ov, ir, ne, lt, ovf, exc;
    logic [31:0] res;
    int k;
    @(negedge clock);
    set_in(n, 1'b1, a, b, op, sh);
    @(posedge clock); #1;
    set_in(n, 1'b0, $urandom, $urandom, 5'($urandom), 5'($urandom));
    k = 0;
    get_out(n, ov, ir, res, ne, lt, ovf, exc);
    while (!ov && k < 40) begin
      @(posedge clock); #1;
      k++;
      get_out(n, ov, ir, res, ne, lt, ovf, exc);
    end
    check({name, " latency"}, 64'(k), 64'(e.lat));
    check({name, " result"}, 64'(res), 64'(e.res));
    check({name, " flags ovf/exc/lt/ne"}, 64'({ovf, exc, lt, ne}), 64'({e.ovf, e.exc, e.lt, e.ne}));
    @(negedge clock);
    if (n) bus8.out_ready = 1'b1; else bus32.out_ready = 1'b1;
    @(posedge clock); #1;
    bus8.out_ready = 1'b0; bus32.out_ready = 1'b0;
    get_out(n, ov, ir, res, ne, lt, ovf, exc);
    check({name, " drained out_valid"}, 64'(ov), 64'd0);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    logic [31:0] minv = 32'd1 << (w - 1);
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return mask;
      3: return minv;
      4: return minv - 1;
      default: return $urandom & mask;
    endcase
  endfunction

  task automatic add(input bit n, input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] op, input logic [4:0] sh, input logic [31:0] res,
                     input logic ovf, input logic exc, input logic lt, input logic ne, input int lat);
    vec_t v;
    v.n = n; v.name = name; v.a = a; v.b = b; v.op = op; v.sh = sh;
    v.e.res = res; v.e.ovf = ovf; v.e.exc = exc; v.e.lt = lt; v.e.ne = ne; v.e.lat = lat;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic ov, ir, ne, lt, ovf, exc;
    logic [31:0] res;
    logic [31:0] ra, rb;
    logic [4:0]  rop, rsh;
    int          cyc;
    bit          nn;

    //   n  name              a             b             op  sh  result        ovf exc lt ne lat
    add(0, "mul -3*7",        32'hFFFFFFFD, 32'd7,        6,  0,  32'hFFFFFFEB, 0,  0,  1, 1, 33);
    add(0, "mul 2^16*2^16",   32'h00010000, 32'h00010000, 6,  0,  32'h0,        1,  0,  0, 0, 33);
    add(0, "mul MIN*-1",      32'h80000000, 32'hFFFFFFFF, 6,  0,  32'h80000000, 1,  0,  1, 1, 33);
    add(0, "mul MIN*1",       32'h80000000, 32'd1,        6,  0,  32'h80000000, 0,  0,  1, 1, 33);
    add(0, "div 5/0",         32'd5,        32'd0,        7,  0,  32'h0,        0,  1,  0, 1, 0);
`ifdef ALU_MULTICYCLE_DIV_EN
    add(0, "div -7/2",        32'hFFFFFFF9, 32'd2,        7,  0,  32'hFFFFFFFD, 0,  0,  1, 1, 33);
    add(0, "div MIN/-1",      32'h80000000, 32'hFFFFFFFF, 7,  0,  32'h80000000, 1,  0,  1, 1, 0);
    add(0, "div 6/3",         32'd6,        32'd3,        7,  0,  32'd2,        0,  0,  0, 1, 33);
`else
    add(0, "div -7/2",        32'hFFFFFFF9, 32'd2,        7,  0,  32'h0,        0,  1,  1, 1, 0);
    add(0, "div MIN/-1",      32'h80000000, 32'hFFFFFFFF, 7,  0,  32'h0,        0,  1,  1, 1, 0);
    add(0, "div 6/3",         32'd6,        32'd3,        7,  0,  32'h0,        0,  1,  0, 1, 0);
`endif
    add(0, "sub MIN-1",       32'h80000000, 32'd1,        1,  0,  32'h7FFFFFFF, 1,  0,  1, 1, 0);
    add(0, "and",             32'hF0F0F0F0, 32'h0FF00FF0, 2,  0,  32'h00F000F0, 0,  0,  1, 1, 0);
    add(0, "or",              32'hF0F0F0F0, 32'h0FF00FF0, 3,  0,  32'hFFF0FFF0, 0,  0,  1, 1, 0);
    add(0, "sll 1<<31",       32'd1,        32'd1,        4,  31, 32'h80000000, 0,  0,  0, 0, 0);
    add(0, "sra by 0",        32'h80001234, 32'h80001234, 5,  0,  32'h80001234, 0,  0,  0, 0, 0);
    add(0, "illegal op 9",    32'd3,        32'd3,        9,  0,  32'h0,        0,  1,  0, 0, 0);
    add(1, "w8 mul 12*10",    32'd12,       32'd10,       6,  0,  32'h78,       0,  0,  0, 1, 9);
    add(1, "w8 sll 0x81<<7",  32'h81,       32'd0,        4,  7,  32'h80,       0,  0,  1, 1, 0);
    add(1, "w8 illegal 9",    32'd0,        32'd0,        9,  0,  32'h0,        0,  1,  0, 0, 0);

    set_in(0, 1'b0, '0, '0, '0, '0);
    set_in(1, 1'b0, '0, '0, '0, '0);
    bus32.out_ready = 1'b0;
    bus8.out_ready  = 1'b0;

    // Reset values
    #12;
    get_out(0, ov, ir, res, ne, lt, ovf, exc);
    check("reset w32 outputs", 64'({ov, ir, res, ne, lt, ovf, exc}), 64'({1'b0, 1'b1, 32'd0, 4'd0}));
    get_out(1, ov, ir, res, ne, lt, ovf, exc);
    check("reset w8 outputs", 64'({ov, ir, res, ne, lt, ovf, exc}), 64'({1'b0, 1'b1, 32'd0, 4'd0}));
    @(negedge clock);
    reset = 1'b1;

    foreach (tbl[i])
      run_op(tbl[i].n, tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].sh, tbl[i].e);

    // Back-to-back ADD then SUB with out_ready held high
    @(negedge clock);
    bus32.out_ready = 1'b1;
    set_in(0, 1'b1, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd0);
    @(negedge clock);
    get_out(0, ov, ir, res, ne, lt, ovf, exc);
    check("b2b add valid/result", 64'({ov, res}), 64'({1'b1, 32'h80000000}));
    check("b2b add ovf", 64'(ovf), 64'd1);
    set_in(0, 1'b1, 32'd5, 32'd7, 5'd1, 5'd0);
    @(negedge clock);
    get_out(0, ov, ir, res, ne, lt, ovf, exc);
    check("b2b sub valid/result", 64'({ov, res}), 64'({1'b1, 32'hFFFFFFFE}));
    check("b2b sub lt/ne/ovf", 64'({lt, ne, ovf}), 64'({1'b1, 1'b1, 1'b0}));
    set_in(0, 1'b0, '0, '0, '0, '0);
    @(negedge clock);
    get_out(0, ov, ir, res, ne, lt, ovf, exc);
    check("b2b drained", 64'(ov), 64'd0);
    bus32.out_ready = 1'b0;

    // Backpressure: SRA held for 5 cycles while a competing request is offered
    @(negedge clock);
    set_in(0, 1'b1, 32'h80000000, 32'd0, 5'd5, 5'd4);
    @(negedge clock);
    set_in(0, 1'b1, 32'd1, 32'd2, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      get_out(0, ov, ir, res, ne, lt, ovf, exc);
      check("backpressure hold", 64'({ov, ir, res}), 64'({1'b1, 1'b0, 32'hF8000000}));
      @(negedge clock);
    end
    set_in(0, 1'b0, '0, '0, '0, '0);
    bus32.out_ready = 1'b1;
    @(negedge clock);
    bus32.out_ready = 1'b0;
    get_out(0, ov, ir, res, ne, lt, ovf, exc);
    check("backpressure release", 64'({ov, ir}), 64'({1'b0, 1'b1}));

    // Reset in the middle of a MUL
    @(negedge clock);
    set_in(0, 1'b1, 32'd1234, 32'd5678, 5'd6, 5'd0);
    @(negedge clock);
    set_in(0, 1'b0, '0, '0, '0, '0);
    cyc = 0;
    repeat (10) @(negedge clock);
    get_out(0, ov, ir, res, ne, lt, ovf, exc);
    check("mid-mul busy", 64'({ov, ir}), 64'({1'b0, 1'b0}));
    reset = 1'b0;
    #1;
    get_out(0, ov, ir, res, ne, lt, ovf, exc);
    check("mid-mul reset outputs", 64'({ov, ir, res, ne, lt, ovf, exc}), 64'({1'b0, 1'b1, 32'd0, 4'd0}));
    @(negedge clock);
    reset = 1'b1;
    repeat (40) begin
      @(negedge clock);
      get_out(0, ov, ir, res, ne, lt, ovf, exc);
      if (ov) cyc++;
    end
    check("no result after abort", 64'(cyc), 64'd0);
    run_op(0, "post-reset mul", 32'hFFFFFFF0, 32'd3, 5'd6, 5'd0, model(32, 32'hFFFFFFF0, 32'd3, 5'd6, 5'd0));

    // Randomized ops on both widths against the reference
    for (int i = 0; i < 60; i++) begin
      nn  = (i % 2 == 1);
      ra  = pick(nn ? 8 : 32);
      rb  = pick(nn ? 8 : 32);
      rop = 5'($urandom_range(0, 9));
      rsh = 5'($urandom);
      run_op(nn, $sformatf("rand%0d w%0d op%0d a=%0h b=%0h sh=%0d", i, nn ? 8 : 32, rop, ra, rb, rsh),
             ra, rb, rop, rsh, model(nn ? 8 : 32, ra, rb, rop, rsh));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
